// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and
// the baud divisor helper used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

    localparam int         SAMPLES_PER_BIT = 16;
    localparam logic [3:0] SAMPLE_FIRST    = 4'd7;
    localparam logic [3:0] SAMPLE_MID      = 4'd8;
    localparam logic [3:0] SAMPLE_LAST     = 4'd9;
    localparam logic [3:0] SAMPLE_END      = 4'd15;

    function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx16_if.sv
// Receive-side bundle: serial line in, byte and status strobes out.
interface uart_rx16_if;
    logic       rx_serial_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    modport master (
        input  rx_serial_in,
        output rx_data, rx_valid, rx_frame_err, rx_busy
    );

    modport slave (
        output rx_serial_in,
        input  rx_data, rx_valid, rx_frame_err, rx_busy
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divisor counter producing a one-clk tick every DIV enabled cycles.
// A synchronous clear realigns the phase, e.g. to a detected start edge.
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx16.sv
// 16x-oversampling UART receiver: majority vote of three mid-bit samples,
// false-start rejection and framing-error reporting.
module uart_rx16
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input logic         clk,
    input logic         rst_n,
    uart_rx16_if.master rx
);
    localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);

    rx_state_e  state_q, state_d;
    logic [1:0] sync_q, sync_d;
    logic [3:0] sample_cnt_q, sample_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic       s7_q, s7_d;
    logic       s8_q, s8_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_frame_err_q, rx_frame_err_d;

    logic line;
    logic tick;
    logic baud_clr;
    logic baud_en;
    logic bit_val;

    assign line    = sync_q[1];
    assign baud_en = (state_q != IDLE);
    assign bit_val = majority3(s7_q, s8_q, line);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (baud_clr),
        .en    (baud_en),
        .tick  (tick)
    );

    always_comb begin
        sync_d         = {sync_q[0], rx.rx_serial_in};
        state_d        = state_q;
        sample_cnt_d   = sample_cnt_q;
        bit_idx_d      = bit_idx_q;
        shift_d        = shift_q;
        s7_d           = s7_q;
        s8_d           = s8_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_frame_err_d = 1'b0;
        baud_clr       = 1'b0;

        if (tick && (state_q inside {START, DATA, STOP})) begin
            sample_cnt_d = sample_cnt_q + 4'd1;
            if (sample_cnt_q == SAMPLE_FIRST) s7_d = line;
            if (sample_cnt_q == SAMPLE_MID)   s8_d = line;
        end

        case (state_q)
            IDLE: begin
                if (!line) begin
                    state_d      = START;
                    baud_clr     = 1'b1;
                    sample_cnt_d = '0;
                    bit_idx_d    = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (sample_cnt_q == SAMPLE_LAST && bit_val) begin
                        state_d = IDLE;
                    end else if (sample_cnt_q == SAMPLE_END) begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (sample_cnt_q == SAMPLE_LAST) shift_d = {bit_val, shift_q[7:1]};
                    if (sample_cnt_q == SAMPLE_END) begin
                        if (bit_idx_q == 3'd7) state_d = STOP;
                        else                   bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit leaves time to catch a back-to-back start edge.
                if (tick && sample_cnt_q == SAMPLE_LAST) begin
                    if (bit_val) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        rx_frame_err_d = 1'b1;
                        sample_cnt_d   = '0;
                        state_d        = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // The sample counter doubles as the run length of consecutive high ticks.
                if (tick) begin
                    if (!line)                           sample_cnt_d = '0;
                    else if (sample_cnt_q == SAMPLE_END) state_d      = IDLE;
                    else                                 sample_cnt_d = sample_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sync_q         <= 2'b11;
            sample_cnt_q   <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            s7_q           <= 1'b1;
            s8_q           <= 1'b1;
            rx_data_q      <= 8'h00;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            sample_cnt_q   <= sample_cnt_d;
            bit_idx_q      <= bit_idx_d;
            shift_q        <= shift_d;
            s7_q           <= s7_d;
            s8_q           <= s8_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
        end
    end

    assign rx.rx_data      = rx_data_q;
    assign rx.rx_valid     = rx_valid_q;
    assign rx.rx_frame_err = rx_frame_err_q;
    assign rx.rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx16.sv
// Directed bench for uart_rx16 at DIV=10 (160 clk per bit): table-driven frames
// plus hand-written sequences for glitch, framing error and mid-frame reset.
module tb_uart_rx16;

    localparam int BIT_CLKS = 160;

    logic clk;
    logic rst_n;

    uart_rx16_if u_if ();

    uart_rx16 #(
        .CLK_FREQ   (1600000),
        .BAUD       (10000),
        .OVERSAMPLE (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int   valid_cnt   = 0;
    int   ferr_cnt    = 0;
    int   overlap_cnt = 0;
    int   long_cnt    = 0;
    logic prev_valid  = 1'b0;
    logic prev_ferr   = 1'b0;

    always @(negedge clk) begin
        if (u_if.rx_valid === 1'b1) valid_cnt++;
        if (u_if.rx_frame_err === 1'b1) ferr_cnt++;
        if (u_if.rx_valid === 1'b1 && u_if.rx_frame_err === 1'b1) overlap_cnt++;
        if ((u_if.rx_valid === 1'b1 && prev_valid) || (u_if.rx_frame_err === 1'b1 && prev_ferr))
            long_cnt++;
        prev_valid = (u_if.rx_valid === 1'b1);
        prev_ferr  = (u_if.rx_frame_err === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_clks(input int n);
        u_if.rx_serial_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, then the given stop level; bclk clk per bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk);
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      u_if.rx_serial_in = 1'b0;
            else if (b == 9) u_if.rx_serial_in = stop;
            else             u_if.rx_serial_in = d[b-1];
            repeat (bclk) @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         bit_clks;
        int         gap_clks;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int v0, f0;

        vecs[0] = '{8'hA5, 1'b1, BIT_CLKS, 200, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, BIT_CLKS, 0,   1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, BIT_CLKS, 0,   1, 0, 8'hFF};
        vecs[3] = '{8'h81, 1'b1, BIT_CLKS, 200, 1, 0, 8'h81};
        vecs[4] = '{8'hC3, 1'b1, 155,      200, 1, 0, 8'hC3};
        vecs[5] = '{8'hC3, 1'b1, 165,      200, 1, 0, 8'hC3};

        u_if.rx_serial_in = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("reset rx_data", 32'(u_if.rx_data), 32'h00);
        check("reset rx_valid", 32'(u_if.rx_valid), 32'd0);
        check("reset rx_frame_err", 32'(u_if.rx_frame_err), 32'd0);
        check("reset rx_busy", 32'(u_if.rx_busy), 32'd0);
        rst_n = 1'b1;
        idle_clks(20);

        for (int i = 0; i < 6; i++) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].bit_clks);
            check($sformatf("row%0d valid count", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
            check($sformatf("row%0d frame_err count", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("row%0d rx_data", i), 32'(u_if.rx_data), 32'(vecs[i].exp_data));
            if (vecs[i].gap_clks > 0) begin
                idle_clks(vecs[i].gap_clks);
                check($sformatf("row%0d busy after gap", i), 32'(u_if.rx_busy), 32'd0);
            end
        end

        // Short low glitch: START entered, then rejected at the count-9 vote.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        u_if.rx_serial_in = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch busy during", 32'(u_if.rx_busy), 32'd1);
        idle_clks(150);
        check("glitch busy after", 32'(u_if.rx_busy), 32'd0);
        check("glitch no valid", 32'(valid_cnt - v0), 32'd0);
        check("glitch no frame_err", 32'(ferr_cnt - f0), 32'd0);
        check("glitch rx_data kept", 32'(u_if.rx_data), 32'hC3);

        // Framing error, line held low, then recovery with a good frame.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, BIT_CLKS);
        check("ferr strobe count", 32'(ferr_cnt - f0), 32'd1);
        check("ferr no valid", 32'(valid_cnt - v0), 32'd0);
        check("ferr rx_data kept", 32'(u_if.rx_data), 32'hC3);
        u_if.rx_serial_in = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("ferr busy while low", 32'(u_if.rx_busy), 32'd1);
        idle_clks(200);
        check("ferr busy after idle", 32'(u_if.rx_busy), 32'd0);
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h5A, 1'b1, BIT_CLKS);
        idle_clks(200);
        check("recover valid count", 32'(valid_cnt - v0), 32'd1);
        check("recover frame_err count", 32'(ferr_cnt - f0), 32'd0);
        check("recover rx_data", 32'(u_if.rx_data), 32'h5A);

        // One-clk reset during data bit 4 of 0x77.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        for (int b = 0; b < 5; b++) begin
            u_if.rx_serial_in = (b == 0) ? 1'b0 : ((8'h77 >> (b - 1)) & 8'h01) != 8'h00;
            repeat ((b == 4) ? BIT_CLKS / 2 : BIT_CLKS) @(negedge clk);
        end
        check("midframe busy before reset", 32'(u_if.rx_busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midframe reset rx_data", 32'(u_if.rx_data), 32'h00);
        check("midframe reset busy", 32'(u_if.rx_busy), 32'd0);
        check("midframe reset valid", 32'(u_if.rx_valid), 32'd0);
        rst_n = 1'b1;
        idle_clks(400);
        check("midframe no valid", 32'(valid_cnt - v0), 32'd0);
        check("midframe no frame_err", 32'(ferr_cnt - f0), 32'd0);
        v0 = valid_cnt;
        send_frame(8'h12, 1'b1, BIT_CLKS);
        idle_clks(200);
        check("post-reset valid count", 32'(valid_cnt - v0), 32'd1);
        check("post-reset rx_data", 32'(u_if.rx_data), 32'h12);

        check("valid/frame_err overlap", 32'(overlap_cnt), 32'd0);
        check("strobe longer than 1 clk", 32'(long_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
